// File: rtl/wf_rr_select_if.sv
`default_nettype none
// ============================================================================
// Module   : wf_rr_select_if
// Purpose  : Request / selection handshake bundle for the round-robin selector.
// Revision : 1.0
// ============================================================================
interface wf_rr_select_if #(
    parameter int BITS = 6,
    parameter int SIZE = 40
);
    logic [SIZE-1:0] req;
    logic            flush;
    logic            out_valid;
    logic [BITS-1:0] out_idx;
    logic            out_ready;

    modport master (
        input  req,
        input  flush,
        input  out_ready,
        output out_valid,
        output out_idx
    );

    modport slave (
        output req,
        output flush,
        output out_ready,
        input  out_valid,
        input  out_idx
    );
endinterface
`default_nettype wire

// File: rtl/wf_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : wf_rr_select
// Purpose  : Round-robin wavefront selector with a registered valid/ready index.
// Revision : 1.0
// ============================================================================
module wf_rr_select #(
    parameter int BITS = 6,
    parameter int SIZE = 40
) (
    input  wire logic         clk,
    input  wire logic         rst,
    wf_rr_select_if.master    bus
);
    localparam logic [BITS-1:0] c_last_idx = BITS'(SIZE - 1);

    logic            r_valid;
    logic [BITS-1:0] r_idx;
    logic [BITS-1:0] r_ptr;

    logic            w_accept;
    logic            w_free;
    logic [BITS-1:0] w_ptr_next;
    logic [SIZE-1:0] w_elig;
    logic            w_any_hi;
    logic            w_any_lo;
    logic            w_any;
    logic [BITS-1:0] w_sel_hi;
    logic [BITS-1:0] w_sel_lo;
    logic [BITS-1:0] w_sel;

    always_comb begin
        w_accept = r_valid & bus.out_ready;
        w_free   = ~r_valid | w_accept;
        if (w_accept) begin
            w_ptr_next = (r_idx == c_last_idx) ? '0 : r_idx + BITS'(1);
        end else begin
            w_ptr_next = r_ptr;
        end
    end

    // Descending scan: the last hit written is the lowest index in each half.
    always_comb begin
        w_elig   = bus.req;
        w_any_hi = 1'b0;
        w_any_lo = 1'b0;
        w_sel_hi = '0;
        w_sel_lo = '0;
        for (int i = SIZE - 1; i >= 0; i--) begin
            if (w_accept && (r_idx == BITS'(i))) begin
                w_elig[i] = 1'b0;
            end
            if (w_elig[i]) begin
                if (BITS'(i) >= w_ptr_next) begin
                    w_any_hi = 1'b1;
                    w_sel_hi = BITS'(i);
                end else begin
                    w_any_lo = 1'b1;
                    w_sel_lo = BITS'(i);
                end
            end
        end
        w_any = w_any_hi | w_any_lo;
        w_sel = w_any_hi ? w_sel_hi : w_sel_lo;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= w_ptr_next;
            end
            if (bus.flush) begin
                r_valid <= 1'b0;
            end else if (w_free) begin
                r_valid <= w_any;
                if (w_any) begin
                    r_idx <= w_sel;
                end
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_idx   = r_idx;
endmodule
`default_nettype wire

// File: tb/tb_wf_rr_select.sv
`default_nettype none
// ============================================================================
// Module   : tb_wf_rr_select
// Purpose  : Self-checking bench for wf_rr_select (SIZE=4, BITS=2).
// Revision : 1.0
// ============================================================================
module tb_wf_rr_select;
    localparam int SIZE = 4;
    localparam int BITS = 2;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    wf_rr_select_if #(.BITS(BITS), .SIZE(SIZE)) bus ();

    wf_rr_select #(.BITS(BITS), .SIZE(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: rotating scan starting at the pointer, skipping the index just granted.
    int mv = 0;
    int mi = 0;
    int mp = 0;

    always @(posedge clk) begin
        bit acc;
        bit found;
        int pick;
        if (!rst) begin
            mv = 0;
            mi = 0;
            mp = 0;
        end else begin
            acc = (mv == 1) && bus.out_ready;
            if (acc) mp = (mi + 1) % SIZE;
            if (bus.flush) begin
                mv = 0;
            end else if ((mv == 0) || acc) begin
                found = 0;
                pick  = 0;
                for (int k = 0; k < SIZE; k++) begin
                    int j;
                    j = (mp + k) % SIZE;
                    if (!found && bus.req[j] && !(acc && (j == mi))) begin
                        found = 1;
                        pick  = j;
                    end
                end
                mv = found ? 1 : 0;
                if (found) mi = pick;
            end
        end
        #1;
        chk("model_valid", int'(bus.out_valid), mv);
        chk("model_idx", int'(bus.out_idx), mi);
    end

    task automatic step(input logic [3:0] r, input logic rdy, input logic fl, input logic rs);
        bus.req       = r;
        bus.out_ready = rdy;
        bus.flush     = fl;
        rst           = rs;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int exp_seq [5] = '{1, 2, 3, 0, 1};
        logic [3:0] r;
        bus.req       = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;
        rst           = 1'b0;

        for (int n = 0; n < 3; n++) begin
            step(4'b1111, 1'b1, 1'b0, 1'b0);
            chk("reset_valid", int'(bus.out_valid), 0);
            chk("reset_idx", int'(bus.out_idx), 0);
        end
        step(4'b1111, 1'b1, 1'b0, 1'b1);
        chk("first_valid", int'(bus.out_valid), 1);
        chk("first_idx", int'(bus.out_idx), 0);

        for (int n = 0; n < 5; n++) begin
            step(4'b1111, 1'b1, 1'b0, 1'b1);
            chk("rot_valid", int'(bus.out_valid), 1);
            chk("rot_idx", int'(bus.out_idx), exp_seq[n]);
        end

        for (int n = 0; n < 5; n++) begin
            step(4'b0110, 1'b0, 1'b0, 1'b1);
            chk("hold_valid", int'(bus.out_valid), 1);
            chk("hold_idx", int'(bus.out_idx), 1);
        end
        step(4'b0000, 1'b0, 1'b0, 1'b1);
        chk("sticky_valid", int'(bus.out_valid), 1);
        chk("sticky_idx", int'(bus.out_idx), 1);
        step(4'b0000, 1'b1, 1'b0, 1'b1);
        chk("drain_valid", int'(bus.out_valid), 0);

        step(4'b0100, 1'b1, 1'b0, 1'b1);
        chk("wrap_pre_idx", int'(bus.out_idx), 2);
        step(4'b0101, 1'b1, 1'b0, 1'b1);
        chk("wrap_idx0", int'(bus.out_idx), 0);
        step(4'b0101, 1'b1, 1'b0, 1'b1);
        chk("wrap_idx2", int'(bus.out_idx), 2);
        step(4'b0101, 1'b1, 1'b0, 1'b1);
        chk("wrap_idx0b", int'(bus.out_idx), 0);

        for (int n = 0; n < 4; n++) begin
            step(4'b0001, 1'b1, 1'b0, 1'b1);
            chk("single_valid", int'(bus.out_valid), n % 2);
            if (bus.out_valid) chk("single_idx", int'(bus.out_idx), 0);
        end

        step(4'b1000, 1'b1, 1'b0, 1'b1);
        chk("fl_load_idx", int'(bus.out_idx), 3);
        step(4'b1000, 1'b0, 1'b1, 1'b1);
        chk("fl_valid", int'(bus.out_valid), 0);
        step(4'b1000, 1'b0, 1'b0, 1'b1);
        chk("fl_reload_valid", int'(bus.out_valid), 1);
        chk("fl_reload_idx", int'(bus.out_idx), 3);
        step(4'b1000, 1'b1, 1'b1, 1'b1);
        chk("fl_acc_valid", int'(bus.out_valid), 0);
        step(4'b1001, 1'b0, 1'b0, 1'b1);
        chk("fl_ptr_idx", int'(bus.out_idx), 0);

        for (int n = 0; n < 3000; n++) begin
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = r & 4'($urandom_range(0, 15));
            step(r, ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) != 0));
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
